// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with 1-cycle registered reads and a
// sequenced bulk-clear engine. Define REGFILE_BYPASS_EN for read-during-write forwarding.
module regfile_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re0,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  input  logic                  clr,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    clearing;
  logic                    wr_en;

  logic [1:0]              re_v;
  logic [ADDR_WIDTH-1:0]   raddr_v [2];
  logic [DATA_WIDTH-1:0]   rdata_q [2];
  logic [DATA_WIDTH-1:0]   rdata_d [2];
  logic [1:0]              rvalid_q;

  assign clearing = (state_q == CLEAR);
  // A clear request in the same cycle takes precedence over the write.
  assign wr_en    = (state_q == IDLE) && we && !clr && !(ZERO_REG && (waddr == '0));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset because the decode stage relies on every entry reading 0 out of reset.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clearing) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign re_v       = {re1, re0};
  assign raddr_v[0] = raddr0;
  assign raddr_v[1] = raddr1;

  // Priority per port: clear in progress, hardwired zero entry, forwarding, array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_d[p] = rdata_q[p];
      if (re_v[p]) begin
        if (clearing) begin
          rdata_d[p] = '0;
        end else if (ZERO_REG && (raddr_v[p] == '0)) begin
          rdata_d[p] = '0;
        end else if (BYPASS && wr_en && (raddr_v[p] == waddr)) begin
          rdata_d[p] = wdata;
        end else begin
          rdata_d[p] = mem_q[raddr_v[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      rvalid_q   <= '0;
    end else begin
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
      rvalid_q   <= re_v;
    end
  end

  assign rdata0  = rdata_q[0];
  assign rdata1  = rdata_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign busy    = clearing;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: vector table for read/write behaviour plus
// hand-written sequences for bulk clear and reset during clear.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re0;
  logic [4:0]  raddr0;
  logic [31:0] rdata0;
  logic        rvalid0;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        rvalid1;
  logic        clr;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] RAW5  = 32'h0000_0022;
  localparam logic [31:0] RAW31 = 32'hCAFE_F00D;
`else
  localparam logic [31:0] RAW5  = 32'h0000_0011;
  localparam logic [31:0] RAW31 = 32'h0000_0000;
`endif

  regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re0     (re0),
    .raddr0  (raddr0),
    .rdata0  (rdata0),
    .rvalid0 (rvalid0),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .rvalid1 (rvalid1),
    .clr     (clr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re0;
    logic [4:0]  raddr0;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] e_rd0;
    logic        e_rv0;
    logic [31:0] e_rd1;
    logic        e_rv1;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    re0 = 1'b0; raddr0 = '0;
    re1 = 1'b0; raddr1 = '0;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    int guard;

    // we, waddr, wdata, re0, raddr0, re1, raddr1 | rd0, rv0, rd1, rv1
    vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 5'd3,  32'hDEADBEEF,  1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3, 1'b1, 5'd3,  32'hDEADBEEF,  1'b1, 32'hDEADBEEF,  1'b1};
    vecs[4]  = '{1'b1, 5'd0,  32'h1234,      1'b0, 5'd0, 1'b0, 5'd0,  32'hDEADBEEF,  1'b0, 32'hDEADBEEF,  1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 1'b1, 5'd3,  32'h0,         1'b1, 32'hDEADBEEF,  1'b1};
    vecs[6]  = '{1'b1, 5'd5,  32'h11,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'hDEADBEEF,  1'b0};
    vecs[7]  = '{1'b1, 5'd5,  32'h22,        1'b1, 5'd5, 1'b1, 5'd3,  RAW5,          1'b1, 32'hDEADBEEF,  1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5, 1'b0, 5'd0,  32'h22,        1'b1, 32'hDEADBEEF,  1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5, 1'b1, 5'd5,  32'h22,        1'b1, 32'h22,        1'b1};
    vecs[10] = '{1'b1, 5'd0,  32'h55,        1'b1, 5'd0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h22,        1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h22,        1'b0};
    vecs[12] = '{1'b1, 5'd31, 32'hCAFEF00D,  1'b0, 5'd0, 1'b1, 5'd31, 32'h0,         1'b0, RAW31,         1'b1};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b1, 5'd31, 32'h0,         1'b0, 32'hCAFEF00D,  1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_rdata0",  rdata0,  32'h0);
    check("reset_rvalid0", {31'b0, rvalid0}, 32'h0);
    check("reset_rvalid1", {31'b0, rvalid1}, 32'h0);
    check("reset_busy",    {31'b0, busy},    32'h0);
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re0 = vecs[i].re0; raddr0 = vecs[i].raddr0;
      re1 = vecs[i].re1; raddr1 = vecs[i].raddr1;
      tick();
      check($sformatf("vec%0d_rdata0", i),  rdata0,            vecs[i].e_rd0);
      check($sformatf("vec%0d_rvalid0", i), {31'b0, rvalid0},  {31'b0, vecs[i].e_rv0});
      check($sformatf("vec%0d_rdata1", i),  rdata1,            vecs[i].e_rd1);
      check($sformatf("vec%0d_rvalid1", i), {31'b0, rvalid1},  {31'b0, vecs[i].e_rv1});
      check($sformatf("vec%0d_busy", i),    {31'b0, busy},     32'h0);
    end
    idle_inputs();

    // Bulk clear: fill, then clr together with a write and a read.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'hA5A5A5A5;
      tick();
    end
    idle_inputs();
    re0 = 1'b1; raddr0 = 5'd4;
    tick();
    check("prefill_read4", rdata0, 32'hA5A5A5A5);

    clr = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h77;
    re0 = 1'b1; raddr0 = 5'd4;
    tick();
    check("clr_edge_busy",  {31'b0, busy}, 32'h1);
    check("clr_edge_rdata", rdata0, 32'hA5A5A5A5);
    idle_inputs();
    busy_cycles = 1;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      re0 = 1'b1; raddr0 = 5'(guard % 32);
      re1 = 1'b1; raddr1 = 5'd31;
      we = 1'b1; waddr = 5'd7; wdata = 32'h99;
      clr = (guard == 10);
      tick();
      check($sformatf("busy_read0_%0d", guard), rdata0, 32'h0);
      check($sformatf("busy_rvalid0_%0d", guard), {31'b0, rvalid0}, 32'h1);
      check($sformatf("busy_read1_%0d", guard), rdata1, 32'h0);
      if (busy === 1'b1) busy_cycles++;
      guard++;
    end
    idle_inputs();
    if (guard >= 100) check("busy_timeout", 32'(guard), 32'd33);
    check("busy_cycles", 32'(busy_cycles), 32'd32);

    for (int i = 0; i < 32; i++) begin
      re0 = 1'b1; raddr0 = 5'(i);
      tick();
      check($sformatf("post_clear_%0d", i), rdata0, 32'h0);
    end
    idle_inputs();
    check("post_clear_busy", {31'b0, busy}, 32'h0);

    // Reset in the middle of a clear.
    we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    re0 = 1'b1; raddr0 = 5'd9; re1 = 1'b1; raddr1 = 5'd9;
    repeat (9) tick();
    check("midclr_busy_before", {31'b0, busy}, 32'h1);
    check("midclr_rvalid0_before", {31'b0, rvalid0}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midclr_busy",    {31'b0, busy},    32'h0);
    check("midclr_rvalid0", {31'b0, rvalid0}, 32'h0);
    check("midclr_rvalid1", {31'b0, rvalid1}, 32'h0);
    check("midclr_rdata0",  rdata0, 32'h0);
    repeat (2) tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    check("after_rst_busy", {31'b0, busy}, 32'h0);
    we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    tick();
    idle_inputs();
    re0 = 1'b1; raddr0 = 5'd6; re1 = 1'b1; raddr1 = 5'd9;
    tick();
    check("after_rst_read6", rdata0, 32'h66);
    check("after_rst_read9", rdata1, 32'h0);
    check("after_rst_rvalid1", {31'b0, rvalid1}, 32'h1);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
